multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL provide: clk  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL provide: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL provide: op  in  7  opcode of the latched instruction.
REQ-004 SHALL provide: zero  in  1  ALU zero flag.
REQ-005 SHALL provide: mem_ready  in  1  memory accepted or returned data this cycle.
REQ-006 SHALL provide: mem_req  out  1  memory access active.
REQ-007 SHALL provide: AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-008 SHALL provide: IRWrite, PCWrite, RegWrite, MemWrite  out  1 each  write strobes.
REQ-009 SHALL provide: ALUSrcA, ALUSrcB, ResultSrc  out  2 each  datapath mux selects.
REQ-010 SHALL provide: ALUOp  out  2  ALU decoder class: 00 add, 01 sub, 10 R-type, 11 I-type.
REQ-011 SHALL provide: instr_done  out  1  one-cycle pulse when an instruction retires.
REQ-012 SHALL provide: illegal  out  1  one-cycle pulse when an opcode is unsupported.

Function
REQ-013 SHALL implement a Moore state register with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, plus JALR and JALRPC when enabled (see Configuration).
REQ-014 SHALL default every output to 0 and ALUSrcA/ALUSrcB/ResultSrc/ALUOp to 00 unless a state sets it.
REQ-015 FETCH SHALL drive mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
- IRWrite and PCWrite SHALL be 1 only when mem_ready=1.
- Go to DECODE when mem_ready=1; otherwise stay in FETCH.
REQ-016 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, ALUOp=00 and branch on op:
- 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL.
- Any other opcode -> FETCH with illegal=1 for that cycle.
REQ-017 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=00, then go to MEMREAD if op=0000011, else MEMWRITE.
REQ-018 MEMREAD SHALL drive mem_req=1, AdrSrc=1 and hold until mem_ready=1, then go to MEMWB.
REQ-019 MEMWB SHALL drive ResultSrc=01, RegWrite=1, instr_done=1, then go to FETCH.
REQ-020 MEMWRITE SHALL drive mem_req=1, AdrSrc=1 and MemWrite=1 level until mem_ready=1, then go to FETCH with instr_done=1 in the accepting cycle.
REQ-021 EXECR SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=10; EXECI SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=11; both go to ALUWB.
REQ-022 ALUWB SHALL drive ResultSrc=00, RegWrite=1, instr_done=1, then go to FETCH.
REQ-023 BEQ SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=zero, instr_done=1, then go to FETCH.
REQ-024 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1, then go to ALUWB.
REQ-025 Cycle counts with mem_ready tied to 1 SHALL be: lw 5, sw 4, R/I 4, beq 3, jal 4.
REQ-026 mem_ready SHALL be ignored in every state other than FETCH, MEMREAD and MEMWRITE.
REQ-027 An unreachable state encoding SHALL return to FETCH on the next edge.

Reset
REQ-028 While rst_n=0, the state SHALL be FETCH (asynchronously) and mem_req, IRWrite, PCWrite, RegWrite, MemWrite, instr_done and illegal SHALL be 0.
REQ-029 Reset asserted mid-instruction SHALL abandon it with no further strobe; the first edge after deassertion SHALL evaluate FETCH.

Configuration
REQ-030 With macro MULTICYCLE_CTRL_JALR_EN defined:
- op 1100111 in DECODE SHALL go to JALR.
- JALR SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=00, then go to JALRPC.
- JALRPC SHALL drive ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1, then go to ALUWB (5 cycles total).
REQ-031 Without the macro, op 1100111 SHALL be illegal per REQ-016, and the JALR and JALRPC states SHALL not exist.

Verification
REQ-032 add (op 0110011), mem_ready=1 -> states FETCH, DECODE, EXECR, ALUWB; ALUOp=10 in EXECR; RegWrite and instr_done in cycle 4 only.
REQ-033 lw, mem_ready low 3 cycles in FETCH and 2 in MEMREAD -> IRWrite and PCWrite exactly once; MemWB reached at cycle 10; RegWrite once.
REQ-034 beq with zero=1 then zero=0 -> PCWrite=1 in BEQ then 0; each takes 3 cycles; ALUOp=01.
REQ-035 op 1111111 -> illegal pulse in DECODE; FETCH next; no RegWrite or MemWrite.
REQ-036 sw with mem_ready low 4 cycles in MEMWRITE -> MemWrite held 5 cycles; instr_done with mem_ready; rst_n pulsed low in MEMWRITE -> MemWrite drops immediately, then FETCH.
REQ-037 op 1100111 -> with the macro: FETCH, DECODE, JALR, JALRPC, ALUWB; without it: illegal pulse.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM; JALR path enabled by MULTICYCLE_CTRL_JALR_EN.
// Latency: lw 5, sw/R/I/jal 4, beq 3 cycles (jalr 5) with mem_ready held high.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold until mem_ready; other states ignore it.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUOp,
    output logic       instr_done,
    output logic       illegal
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
`ifdef MULTICYCLE_CTRL_JALR_EN
    localparam logic [6:0] OP_JALR = 7'b1100111;
`endif

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
`ifdef MULTICYCLE_CTRL_JALR_EN
        JAL      = 4'd10,
        JALR     = 4'd11,
        JALRPC   = 4'd12
`else
        JAL      = 4'd10
`endif
    } state_t;

    state_t state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUOp      = 2'b00;
        instr_done = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECR;
                    OP_I:         state_d = EXECI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
`ifdef MULTICYCLE_CTRL_JALR_EN
                    OP_JALR:      state_d = JALR;
`endif
                    default: begin
                        illegal = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            MEMWRITE: begin
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                state_d = ALUWB;
            end
            EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b11;
                state_d = ALUWB;
            end
            ALUWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            BEQ: begin
                ALUSrcA    = 2'b10;
                ALUOp      = 2'b01;
                PCWrite    = zero;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                state_d = ALUWB;
            end
`ifdef MULTICYCLE_CTRL_JALR_EN
            JALR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = JALRPC;
            end
            JALRPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                state_d = ALUWB;
            end
`endif
            default: state_d = FETCH;
        endcase

        // Outputs are quiet while reset is held, even though the state already reads FETCH.
        if (!rst_n) begin
            state_d    = FETCH;
            mem_req    = 1'b0;
            AdrSrc     = 1'b0;
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            RegWrite   = 1'b0;
            MemWrite   = 1'b0;
            ALUSrcA    = 2'b00;
            ALUSrcB    = 2'b00;
            ResultSrc  = 2'b00;
            ALUOp      = 2'b00;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl against an instruction-level model.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUOp;
    logic       instr_done, illegal;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ALUOp      (ALUOp),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    logic [15:0] obs;
    assign obs = {mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite,
                  ALUSrcA, ALUSrcB, ResultSrc, ALUOp, instr_done, illegal};

    localparam logic [15:0] STROBE_MASK = 16'b1011_1100_0000_0011;

    localparam int ST_F = 0, ST_D = 1, ST_MA = 2, ST_MR = 3, ST_MWB = 4, ST_MWR = 5,
                   ST_ER = 6, ST_EI = 7, ST_AWB = 8, ST_BEQ = 9, ST_JAL = 10,
                   ST_JR = 11, ST_JRPC = 12;
    localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_BEQ = 4, C_JAL = 5,
                   C_JALR = 6, C_ILL = 7;

    function automatic int op_class(logic [6:0] o);
        case (o)
            7'b0000011: return C_LW;
            7'b0100011: return C_SW;
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b1100011: return C_BEQ;
            7'b1101111: return C_JAL;
`ifdef MULTICYCLE_CTRL_JALR_EN
            7'b1100111: return C_JALR;
`endif
            default:    return C_ILL;
        endcase
    endfunction

    // Expected control word for one step of an instruction, straight from the output table.
    function automatic logic [15:0] exp_word(int st, logic mr, logic z, int cls);
        logic mq, ad, ir, pc, rw, mw, dn, il;
        logic [1:0] a, b, r, u;
        {mq, ad, ir, pc, rw, mw, dn, il} = 8'h00;
        {a, b, r, u} = 8'h00;
        case (st)
            ST_F:    begin mq = 1; b = 2'b10; r = 2'b10; ir = mr; pc = mr; end
            ST_D:    begin a = 2'b01; b = 2'b01; il = (cls == C_ILL); end
            ST_MA:   begin a = 2'b10; b = 2'b01; end
            ST_MR:   begin mq = 1; ad = 1; end
            ST_MWB:  begin r = 2'b01; rw = 1; dn = 1; end
            ST_MWR:  begin mq = 1; ad = 1; mw = 1; dn = mr; end
            ST_ER:   begin a = 2'b10; u = 2'b10; end
            ST_EI:   begin a = 2'b10; b = 2'b01; u = 2'b11; end
            ST_AWB:  begin rw = 1; dn = 1; end
            ST_BEQ:  begin a = 2'b10; u = 2'b01; pc = z; dn = 1; end
            ST_JAL:  begin a = 2'b01; b = 2'b10; pc = 1; end
            ST_JR:   begin a = 2'b10; b = 2'b01; end
            ST_JRPC: begin a = 2'b01; b = 2'b10; pc = 1; end
            default: ;
        endcase
        return {mq, ad, ir, pc, rw, mw, a, b, r, u, dn, il};
    endfunction

    // Runs one instruction cycle by cycle; abort_at >= 0 stops before that cycle.
    task automatic run_instr(input logic [6:0] o, input logic z, input int f_stall,
                             input int m_stall, input int abort_at,
                             output int cycles, output int n_ir, output int n_pc,
                             output int n_rw, output int n_mw, output int done_cyc);
        int seq[$];
        int cls;
        int stall;
        logic mr;
        logic [15:0] exp;
        cls = op_class(o);
        case (cls)
            C_LW:    seq = '{ST_F, ST_D, ST_MA, ST_MR, ST_MWB};
            C_SW:    seq = '{ST_F, ST_D, ST_MA, ST_MWR};
            C_R:     seq = '{ST_F, ST_D, ST_ER, ST_AWB};
            C_I:     seq = '{ST_F, ST_D, ST_EI, ST_AWB};
            C_BEQ:   seq = '{ST_F, ST_D, ST_BEQ};
            C_JAL:   seq = '{ST_F, ST_D, ST_JAL, ST_AWB};
            C_JALR:  seq = '{ST_F, ST_D, ST_JR, ST_JRPC, ST_AWB};
            default: seq = '{ST_F, ST_D};
        endcase
        cycles = 0; n_ir = 0; n_pc = 0; n_rw = 0; n_mw = 0; done_cyc = 0;
        foreach (seq[i]) begin
            if (seq[i] == ST_F)                          stall = f_stall;
            else if (seq[i] == ST_MR || seq[i] == ST_MWR) stall = m_stall;
            else                                          stall = 0;
            for (int k = 0; k <= stall; k++) begin
                if (cycles == abort_at) return;
                if (seq[i] == ST_F || seq[i] == ST_MR || seq[i] == ST_MWR)
                    mr = (k == stall);
                else
                    mr = 1'($urandom);
                @(negedge clk);
                op = o; zero = z; mem_ready = mr;
                #1;
                cycles++;
                exp = exp_word(seq[i], mr, z, cls);
                n_checks++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL step op=%b st=%0d cyc=%0d: got %h want %h", o, seq[i], cycles, obs, exp);
                end
                n_ir += int'(IRWrite);
                n_pc += int'(PCWrite);
                n_rw += int'(RegWrite);
                n_mw += int'(MemWrite);
                if (instr_done) done_cyc = cycles;
            end
        end
    endtask

    int cy, ir, pc, rw, mw, dc;

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b0; op = 7'b0000011; zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ready = 1'($urandom); op = 7'($urandom);
            #1;
            n_checks++;
            if ((obs & STROBE_MASK) !== 16'h0) begin
                n_fail++;
                $display("FAIL reset_strobes: got %h want 0000", obs & STROBE_MASK);
            end
        end
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        run_instr(7'b0110011, 1'b0, 0, 0, -1, cy, ir, pc, rw, mw, dc);
        n_checks++;
        if (cy !== 4 || rw !== 1 || dc !== 4) begin
            n_fail++;
            $display("FAIL add: cycles %0d rw %0d done@%0d want 4 1 4", cy, rw, dc);
        end
    endtask

    task automatic test_cycle_counts();
        logic [6:0] ops [5];
        int want [5];
        ops  = '{7'b0000011, 7'b0100011, 7'b0010011, 7'b1100011, 7'b1101111};
        want = '{5, 4, 4, 3, 4};
        for (int i = 0; i < 5; i++) begin
            run_instr(ops[i], 1'b1, 0, 0, -1, cy, ir, pc, rw, mw, dc);
            n_checks++;
            if (cy !== want[i] || dc !== want[i]) begin
                n_fail++;
                $display("FAIL cycles op=%b: got %0d done@%0d want %0d", ops[i], cy, dc, want[i]);
            end
        end
    endtask

    task automatic test_lw_stall();
        run_instr(7'b0000011, 1'b0, 3, 2, -1, cy, ir, pc, rw, mw, dc);
        n_checks++;
        if (cy !== 10 || ir !== 1 || pc !== 1 || rw !== 1 || dc !== 10) begin
            n_fail++;
            $display("FAIL lw_stall: cyc %0d ir %0d pc %0d rw %0d done@%0d want 10 1 1 1 10", cy, ir, pc, rw, dc);
        end
    endtask

    task automatic test_beq();
        run_instr(7'b1100011, 1'b1, 0, 0, -1, cy, ir, pc, rw, mw, dc);
        n_checks++;
        if (cy !== 3 || pc !== 2) begin
            n_fail++;
            $display("FAIL beq_taken: cyc %0d pc %0d want 3 2", cy, pc);
        end
        run_instr(7'b1100011, 1'b0, 0, 0, -1, cy, ir, pc, rw, mw, dc);
        n_checks++;
        if (cy !== 3 || pc !== 1) begin
            n_fail++;
            $display("FAIL beq_not_taken: cyc %0d pc %0d want 3 1", cy, pc);
        end
    endtask

    task automatic test_illegal();
        run_instr(7'b1111111, 1'b0, 0, 0, -1, cy, ir, pc, rw, mw, dc);
        n_checks++;
        if (cy !== 2 || rw !== 0 || mw !== 0 || dc !== 0) begin
            n_fail++;
            $display("FAIL illegal: cyc %0d rw %0d mw %0d done@%0d want 2 0 0 0", cy, rw, mw, dc);
        end
    endtask

    task automatic test_sw_stall();
        run_instr(7'b0100011, 1'b0, 0, 4, -1, cy, ir, pc, rw, mw, dc);
        n_checks++;
        if (cy !== 8 || mw !== 5 || dc !== 8) begin
            n_fail++;
            $display("FAIL sw_stall: cyc %0d mw %0d done@%0d want 8 5 8", cy, mw, dc);
        end
    endtask

    task automatic test_reset_midwrite();
        // Stop after F, D, MA and two stalled MEMWRITE cycles; inputs left with mem_ready=0.
        run_instr(7'b0100011, 1'b0, 0, 10, 5, cy, ir, pc, rw, mw, dc);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (MemWrite !== 1'b1) begin
            n_fail++;
            $display("FAIL midwrite_pre: MemWrite %b want 1", MemWrite);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ((obs & STROBE_MASK) !== 16'h0) begin
            n_fail++;
            $display("FAIL midwrite_reset: got %h want 0000", obs & STROBE_MASK);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (obs !== exp_word(ST_F, 1'b0, zero, C_ILL)) begin
            n_fail++;
            $display("FAIL midwrite_fetch: got %h want %h", obs, exp_word(ST_F, 1'b0, zero, C_ILL));
        end
    endtask

    task automatic test_jalr();
        run_instr(7'b1100111, 1'b0, 0, 0, -1, cy, ir, pc, rw, mw, dc);
        n_checks++;
`ifdef MULTICYCLE_CTRL_JALR_EN
        if (cy !== 5 || rw !== 1 || pc !== 2 || dc !== 5) begin
            n_fail++;
            $display("FAIL jalr: cyc %0d rw %0d pc %0d done@%0d want 5 1 2 5", cy, rw, pc, dc);
        end
`else
        if (cy !== 2 || rw !== 0 || dc !== 0) begin
            n_fail++;
            $display("FAIL jalr_illegal: cyc %0d rw %0d done@%0d want 2 0 0", cy, rw, dc);
        end
`endif
    endtask

    task automatic test_random();
        logic [6:0] pool [9];
        logic [6:0] o;
        int sel, fs, ms, want;
        pool = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                 7'b1101111, 7'b1100111, 7'b1111111, 7'b0000000};
        for (int n = 0; n < 80; n++) begin
            sel = int'($urandom_range(0, 9));
            o   = (sel == 9) ? 7'($urandom) : pool[sel];
            fs  = int'($urandom_range(0, 3));
            ms  = int'($urandom_range(0, 3));
            run_instr(o, 1'($urandom), fs, ms, -1, cy, ir, pc, rw, mw, dc);
            case (op_class(o))
                C_LW:    want = 5 + fs + ms;
                C_SW:    want = 4 + fs + ms;
                C_BEQ:   want = 3 + fs;
                C_JALR:  want = 5 + fs;
                C_ILL:   want = 2 + fs;
                default: want = 4 + fs;
            endcase
            n_checks++;
            if (cy !== want || ir !== 1) begin
                n_fail++;
                $display("FAIL rand_len op=%b: cyc %0d ir %0d want %0d 1", o, cy, ir, want);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_cycle_counts();
        test_lw_stall();
        test_beq();
        test_illegal();
        test_sw_stall();
        test_reset_midwrite();
        test_jalr();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
